axi4_lite_csr_master: RTL
=========================

AXI4_LITE_CSR_MASTER -- requirements
Module: axi4_lite_csr_master

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, meaning the command and AXI address width.
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 1024, meaning the cycles allowed per transaction before abort.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset: clk_i  input  1  clock; rst_n_i  input  1  async active-low reset.
REQ-004 The block SHALL have the following command ports:
- cmd_valid_i  input  1  command present.
- cmd_ready_o  output  1  command accepted.
- cmd_wr_i  input  1  1=write, 0=read.
- cmd_addr_i  input  ADDR_W  byte address.
- cmd_wdata_i  input  32  write data.
- cmd_wstrb_i  input  4  write strobes.
REQ-005 The block SHALL have the following response ports:
- rsp_valid_o  output  1  response present.
- rsp_ready_i  input  1  response consumed.
- rsp_rdata_o  output  32  read data (0 for writes).
- rsp_resp_o  output  2  AXI response code.
- rsp_timeout_o  output  1  transaction aborted by timeout.
REQ-006 The block SHALL have csr_o, an axi4_lite_if.master interface, as the initiator toward CSR slaves.

Function
REQ-007 The block SHALL use an FSM with states IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA and RSP.
REQ-008 cmd_ready_o SHALL be 1 only in IDLE; a command is accepted on cmd_valid_i && cmd_ready_o and its fields are latched on that cycle.
REQ-009 On an accepted write, the block SHALL enter WR_REQ on the next cycle with awvalid=1 and wvalid=1 simultaneously, with awaddr, wdata and wstrb taken from the latched command.
REQ-010 In WR_REQ, awvalid and wvalid SHALL each drop independently after their own handshake, and the FSM SHALL move to WR_RESP the cycle after both handshakes have completed, in either order or together.
REQ-011 In WR_RESP, bready SHALL be 1; on a B handshake the FSM SHALL capture bresp and move to RSP with rsp_rdata_o=0.
REQ-012 On an accepted read, the block SHALL enter RD_REQ with arvalid=1, held until the AR handshake, then move to RD_DATA.
REQ-013 In RD_DATA, rready SHALL be 1; on an R handshake the FSM SHALL capture rdata and rresp and move to RSP.
REQ-014 In RSP, rsp_valid_o SHALL be 1 with stable data; on rsp_ready_i the FSM SHALL return to IDLE, and a new command SHALL NOT be accepted in that same cycle.
REQ-015 AXI address, data and strobe outputs SHALL hold stable while their valid is asserted; awprot and arprot SHALL be 3'b000.
REQ-016 Minimum latency SHALL be: write, command accept to rsp_valid_o = 3 cycles with a zero-wait slave; read, command accept to rsp_valid_o = 3 cycles with a one-cycle-latency slave.
REQ-017 A B or R response SHALL be accepted only in WR_RESP or RD_DATA respectively; bready and rready SHALL be 0 in all other states.

Reset
REQ-018 While rst_n_i=0, all state SHALL clear asynchronously: FSM=IDLE, all AXI valid and ready outputs=0, cmd_ready_o=0, rsp_valid_o=0, rsp_rdata_o=0, rsp_resp_o=0, rsp_timeout_o=0, latched command=0 and timeout counter=0.
REQ-019 cmd_ready_o SHALL assert on the first clock edge after reset deassertion.
REQ-020 A reset mid-transaction SHALL abandon the transaction without producing a response.

Configuration
REQ-021 With macro AXI4_LITE_CSR_MASTER_TIMEOUT_EN defined, a counter SHALL clear on command accept and increment in WR_REQ, WR_RESP, RD_REQ and RD_DATA.
REQ-022 With AXI4_LITE_CSR_MASTER_TIMEOUT_EN defined, when the counter reaches TIMEOUT_CYCLES-1 without completion, the block SHALL deassert all AXI valids and readies and enter RSP with rsp_resp_o=2'b10, rsp_timeout_o=1 and rsp_rdata_o=0.
REQ-023 With AXI4_LITE_CSR_MASTER_TIMEOUT_EN defined, a handshake completing in the same cycle as the timeout SHALL take precedence over the timeout.
REQ-024 Without AXI4_LITE_CSR_MASTER_TIMEOUT_EN, no counter SHALL exist, the block SHALL wait indefinitely, and rsp_timeout_o SHALL be tied to 0.

Structure
REQ-025 Package axi4_lite_csr_master_pkg SHALL hold the FSM state enum and the RESP_OKAY, RESP_EXOKAY, RESP_SLVERR and RESP_DECERR constants.
REQ-026 The timeout counter SHALL be the sub-module axi4_lite_csr_master_timeout, instantiated only when AXI4_LITE_CSR_MASTER_TIMEOUT_EN is defined.

Verification
REQ-027 The bench SHALL cover: write addr 0x0C, data 0xDEADBEEF, wstrb 0xF, zero-wait slave -> AW and W in the same cycle, then rsp_valid_o with resp 0 and timeout 0.
REQ-028 The bench SHALL cover: write where the slave accepts W 3 cycles before AW -> wvalid drops after its handshake, awvalid stays high until its handshake, then exactly one B handshake.
REQ-029 The bench SHALL cover: read addr 0x14 from a slave returning 0x00000123 after 2 wait cycles -> rsp_rdata_o=0x00000123, rsp_resp_o=0.
REQ-030 The bench SHALL cover: rsp_ready_i held 0 for 5 cycles -> rsp_valid_o and its data stable throughout, and cmd_ready_o=0 until one cycle after consumption.
REQ-031 The bench SHALL cover, with AXI4_LITE_CSR_MASTER_TIMEOUT_EN defined and TIMEOUT_CYCLES=16, a slave that never asserts bvalid -> rsp_resp_o=2'b10, rsp_timeout_o=1 within 16 cycles, then the next command completes normally.
REQ-032 The bench SHALL cover: rst_n_i pulsed low during RD_DATA -> all valids 0 immediately, no response produced, and cmd_ready_o=1 on the first edge after release.

Source files
------------

// File: rtl/axi4_lite_csr_master_pkg.sv
// Shared types and constants for the AXI4-Lite CSR master.
package axi4_lite_csr_master_pkg;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StWrReq  = 3'd1,
        StWrResp = 3'd2,
        StRdReq  = 3'd3,
        StRdData = 3'd4,
        StRsp    = 3'd5
    } state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/axi4_lite_csr_master_if.sv
// AXI4-Lite bus bundle with initiator (master) and target (slave) views.
interface axi4_lite_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              awvalid;
    logic              awready;
    logic [ADDR_W-1:0] awaddr;
    logic [2:0]        awprot;
    logic              wvalid;
    logic              wready;
    logic [31:0]       wdata;
    logic [3:0]        wstrb;
    logic              bvalid;
    logic              bready;
    logic [1:0]        bresp;
    logic              arvalid;
    logic              arready;
    logic [ADDR_W-1:0] araddr;
    logic [2:0]        arprot;
    logic              rvalid;
    logic              rready;
    logic [31:0]       rdata;
    logic [1:0]        rresp;

    modport master (
        output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
        output arvalid, araddr, arprot, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
        input  arvalid, araddr, arprot, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/axi4_lite_csr_master_timeout.sv
// Per-transaction watchdog: clears on command accept, counts busy cycles and
// flags expiry once TIMEOUT_CYCLES busy cycles have elapsed. The count holds at
// its terminal value so a handshake that wins against expiry cannot wrap it.
module axi4_lite_csr_master_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic clear_i,
    input  logic en_i,
    output logic expired_o
);
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES - 1);

    logic [CntW-1:0] cnt_q;

    assign expired_o = (cnt_q == CntMax);

    // Count busy cycles, saturating at the terminal value.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else if (clear_i) begin
            cnt_q <= '0;
        end else if (en_i && !expired_o) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end
endmodule

// File: rtl/axi4_lite_csr_master.sv
// Single-outstanding AXI4-Lite initiator driven by a simple command/response
// handshake. Optional watchdog enabled with macro AXI4_LITE_CSR_MASTER_TIMEOUT_EN.
module axi4_lite_csr_master
    import axi4_lite_csr_master_pkg::*;
#(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic              cmd_wr_i,
    input  logic [ADDR_W-1:0] cmd_addr_i,
    input  logic [31:0]       cmd_wdata_i,
    input  logic [3:0]        cmd_wstrb_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [31:0]       rsp_rdata_o,
    output logic [1:0]        rsp_resp_o,
    output logic              rsp_timeout_o,
    axi4_lite_if.master       csr_o
);
    if (TIMEOUT_CYCLES < 2) begin : g_bad_cfg
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    state_e            state_q;
    logic              cmd_ready_q;
    logic              rsp_valid_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [3:0]        wstrb_q;
    logic              awvalid_q;
    logic              wvalid_q;
    logic              bready_q;
    logic              arvalid_q;
    logic              rready_q;
    logic [31:0]       rsp_rdata_q;
    logic [1:0]        rsp_resp_q;

    logic cmd_accept;
    logic aw_hs, w_hs, b_hs, ar_hs, r_hs, any_hs;
    logic busy;
    logic timeout_hit;

    assign cmd_accept = (state_q == StIdle) && cmd_valid_i && cmd_ready_q;
    assign aw_hs      = awvalid_q && csr_o.awready;
    assign w_hs       = wvalid_q && csr_o.wready;
    assign b_hs       = bready_q && csr_o.bvalid;
    assign ar_hs      = arvalid_q && csr_o.arready;
    assign r_hs       = rready_q && csr_o.rvalid;
    // Valids/readies are only ever high in their own state, so any handshake
    // here is progress in the current state.
    assign any_hs     = aw_hs || w_hs || b_hs || ar_hs || r_hs;
    assign busy       = (state_q == StWrReq) || (state_q == StWrResp) ||
                        (state_q == StRdReq) || (state_q == StRdData);

`ifdef AXI4_LITE_CSR_MASTER_TIMEOUT_EN
    logic rsp_timeout_q;

    axi4_lite_csr_master_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .clear_i  (cmd_accept),
        .en_i     (busy),
        .expired_o(timeout_hit)
    );

    assign rsp_timeout_o = rsp_timeout_q;
`else
    assign timeout_hit   = 1'b0;
    assign rsp_timeout_o = 1'b0;
`endif

    assign cmd_ready_o   = cmd_ready_q;
    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_rdata_o   = rsp_rdata_q;
    assign rsp_resp_o    = rsp_resp_q;

    assign csr_o.awvalid = awvalid_q;
    assign csr_o.awaddr  = addr_q;
    assign csr_o.awprot  = 3'b000;
    assign csr_o.wvalid  = wvalid_q;
    assign csr_o.wdata   = wdata_q;
    assign csr_o.wstrb   = wstrb_q;
    assign csr_o.bready  = bready_q;
    assign csr_o.arvalid = arvalid_q;
    assign csr_o.araddr  = addr_q;
    assign csr_o.arprot  = 3'b000;
    assign csr_o.rready  = rready_q;

    // Transaction FSM with all bus and response outputs registered.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q       <= StIdle;
            cmd_ready_q   <= 1'b0;
            rsp_valid_q   <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            awvalid_q     <= 1'b0;
            wvalid_q      <= 1'b0;
            bready_q      <= 1'b0;
            arvalid_q     <= 1'b0;
            rready_q      <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_resp_q    <= RESP_OKAY;
`ifdef AXI4_LITE_CSR_MASTER_TIMEOUT_EN
            rsp_timeout_q <= 1'b0;
`endif
        end else if (busy && timeout_hit && !any_hs) begin
            // Abort: drop every valid/ready and report SLVERR with timeout.
            awvalid_q     <= 1'b0;
            wvalid_q      <= 1'b0;
            bready_q      <= 1'b0;
            arvalid_q     <= 1'b0;
            rready_q      <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_resp_q    <= RESP_SLVERR;
            rsp_valid_q   <= 1'b1;
            state_q       <= StRsp;
`ifdef AXI4_LITE_CSR_MASTER_TIMEOUT_EN
            rsp_timeout_q <= 1'b1;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (cmd_accept) begin
                        cmd_ready_q <= 1'b0;
                        addr_q      <= cmd_addr_i;
                        wdata_q     <= cmd_wdata_i;
                        wstrb_q     <= cmd_wstrb_i;
                        if (cmd_wr_i) begin
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            state_q   <= StWrReq;
                        end else begin
                            arvalid_q <= 1'b1;
                            state_q   <= StRdReq;
                        end
                    end else begin
                        cmd_ready_q <= 1'b1;
                    end
                end
                StWrReq: begin
                    if (aw_hs) awvalid_q <= 1'b0;
                    if (w_hs)  wvalid_q  <= 1'b0;
                    // Both channels done once each is either finished earlier or finishing now.
                    if ((!awvalid_q || aw_hs) && (!wvalid_q || w_hs)) begin
                        bready_q <= 1'b1;
                        state_q  <= StWrResp;
                    end
                end
                StWrResp: begin
                    if (b_hs) begin
                        bready_q      <= 1'b0;
                        rsp_resp_q    <= csr_o.bresp;
                        rsp_rdata_q   <= '0;
                        rsp_valid_q   <= 1'b1;
                        state_q       <= StRsp;
`ifdef AXI4_LITE_CSR_MASTER_TIMEOUT_EN
                        rsp_timeout_q <= 1'b0;
`endif
                    end
                end
                StRdReq: begin
                    if (ar_hs) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= StRdData;
                    end
                end
                StRdData: begin
                    if (r_hs) begin
                        rready_q      <= 1'b0;
                        rsp_rdata_q   <= csr_o.rdata;
                        rsp_resp_q    <= csr_o.rresp;
                        rsp_valid_q   <= 1'b1;
                        state_q       <= StRsp;
`ifdef AXI4_LITE_CSR_MASTER_TIMEOUT_EN
                        rsp_timeout_q <= 1'b0;
`endif
                    end
                end
                StRsp: begin
                    // cmd_ready rises on the following cycle, never in the consuming one.
                    if (rsp_ready_i) begin
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end
endmodule
